// File: rtl/fetch_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_sequencer_if
//  Description : Control/status bundle between the fetch sequencer and the
//                PC/MAR/MDR/IR datapath plus operator controls.
//  Revision    : 1.0 - initial release
// ============================================================================
interface fetch_sequencer_if;
   // Operator and datapath inputs to the sequencer
   logic        run;
   logic        cont;
   logic [3:0]  ir_opcode;
   // Datapath load enables
   logic        ld_mar;
   logic        ld_pc;
   logic        ld_mdr;
   logic        ld_ir;
   // Bus gates
   logic        gate_pc;
   logic        gate_mdr;
   logic        gate_alu;
   logic        gate_marmux;
   // PC source select and memory strobe
   logic [1:0]  pcmux;
   logic        mem_oe;
   // Status
   logic        halted;
   logic        paused;
   logic [15:0] instr_count;

   // Sequencer side
   modport master (
      input  run, cont, ir_opcode,
      output ld_mar, ld_pc, ld_mdr, ld_ir,
      output gate_pc, gate_mdr, gate_alu, gate_marmux,
      output pcmux, mem_oe, halted, paused, instr_count
   );

   // Datapath / operator side
   modport slave (
      output run, cont, ir_opcode,
      input  ld_mar, ld_pc, ld_mdr, ld_ir,
      input  gate_pc, gate_mdr, gate_alu, gate_marmux,
      input  pcmux, mem_oe, halted, paused, instr_count
   );
endinterface
`default_nettype wire

// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_sequencer
//  Description : Moore control FSM running instruction fetch (MAR<-PC,
//                PC<-PC+1, MDR<-M[MAR], IR<-MDR, decode), then pausing for an
//                operator Continue press; a TRAP opcode returns to HALTED.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_sequencer #(
   // Read-strobe cycles before the MDR load; legal range 1..15
   parameter int MEM_WAIT = 2
) (
   input  logic              clk,
   input  logic              rst,
   fetch_sequencer_if.master bus_if
);

   localparam logic [3:0] c_LAST_WAIT = 4'(MEM_WAIT - 1);
   localparam logic [3:0] c_OP_TRAP   = 4'hF;

   typedef enum logic [2:0] {
      ST_HALTED  = 3'd0,
      ST_S18     = 3'd1,
      ST_S33     = 3'd2,
      ST_S35     = 3'd3,
      ST_S32     = 3'd4,
      ST_PAUSE_1 = 3'd5,
      ST_PAUSE_2 = 3'd6
   } state_t;

   state_t      state_q, state_d;
   logic [3:0]  wait_cnt_q, wait_cnt_d;
   logic [15:0] count_q, count_d;

   // State, wait-counter and instruction-counter registers; reset wins over all
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_HALTED;
         wait_cnt_q <= 4'd0;
         count_q    <= 16'd0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         count_q    <= count_d;
      end
   end

   // Next-state logic; wait_cnt defaults to 0 so it is cleared on S33 entry
   always_comb begin
      state_d    = state_q;
      wait_cnt_d = 4'd0;
      count_d    = count_q;
      case (state_q)
         ST_HALTED: begin
            // Run takes priority over Continue here: Continue is not looked at
            if (bus_if.run) state_d = ST_S18;
         end
         ST_S18: state_d = ST_S33;
         ST_S33: begin
            if (wait_cnt_q == c_LAST_WAIT) begin
               state_d = ST_S35;
            end else begin
               wait_cnt_d = wait_cnt_q + 4'd1;
            end
         end
         ST_S35: state_d = ST_S32;
         ST_S32: begin
            count_d = count_q + 16'd1;
            state_d = (bus_if.ir_opcode == c_OP_TRAP) ? ST_HALTED : ST_PAUSE_1;
         end
         ST_PAUSE_1: begin
            if (bus_if.cont) state_d = ST_PAUSE_2;
         end
         ST_PAUSE_2: begin
            // Release of Continue launches exactly one new fetch
            if (!bus_if.cont) state_d = ST_S18;
         end
         default: state_d = ST_HALTED;
      endcase
   end

   // Moore output decode; only one bus gate per state
   always_comb begin
      bus_if.ld_mar      = 1'b0;
      bus_if.ld_pc       = 1'b0;
      bus_if.ld_mdr      = 1'b0;
      bus_if.ld_ir       = 1'b0;
      bus_if.gate_pc     = 1'b0;
      bus_if.gate_mdr    = 1'b0;
      bus_if.gate_alu    = 1'b0;
      bus_if.gate_marmux = 1'b0;
      bus_if.pcmux       = 2'b00;
      bus_if.mem_oe      = 1'b0;
      bus_if.halted      = 1'b0;
      bus_if.paused      = 1'b0;
      case (state_q)
         ST_HALTED: bus_if.halted = 1'b1;
         ST_S18: begin
            bus_if.gate_pc = 1'b1;
            bus_if.ld_mar  = 1'b1;
            bus_if.ld_pc   = 1'b1;
         end
         ST_S33: begin
            bus_if.mem_oe = 1'b1;
            bus_if.ld_mdr = (wait_cnt_q == c_LAST_WAIT);
         end
         ST_S35: begin
            bus_if.gate_mdr = 1'b1;
            bus_if.ld_ir    = 1'b1;
         end
         ST_PAUSE_1, ST_PAUSE_2: bus_if.paused = 1'b1;
         default: ;
      endcase
   end

   assign bus_if.instr_count = count_q;

endmodule
`default_nettype wire
